// File: rtl/pedest_pkg.sv
// Shared definitions for the pedestrian button input and lamp output devices:
// CSR bit positions, lamp command codes, FSM state encoding and a lamp decoder.
package pedest_pkg;

  // CSR bit indices (common register model for both pedestrian devices)
  localparam int CSR_ENA  = 4;
  localparam int CSR_OF   = 3;
  localparam int CSR_DBA  = 2;
  localparam int CSR_BUSY = 1;
  localparam int CSR_IE   = 0;

  // Lamp command codes carried in DR[1:0]
  localparam logic [1:0] CMD_OFF   = 2'b00;
  localparam logic [1:0] CMD_WALK  = 2'b01;
  localparam logic [1:0] CMD_FLASH = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pedest_state_t;

  // Lamp pattern {walk, dont_walk} for a command; phase drives flashing DON'T-WALK
  function automatic logic [1:0] lamp_decode(input logic [1:0] cmd, input logic phase);
    logic [1:0] lamps;
    case (cmd)
      CMD_OFF:   lamps = 2'b00;
      CMD_WALK:  lamps = 2'b10;
      CMD_FLASH: lamps = {1'b0, phase};
      CMD_STOP:  lamps = 2'b01;
      default:   lamps = 2'b01;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/pedest_tick_gen.sv
// Free-running divider: one-cycle pulse on the last cycle of every DIV enabled
// cycles. A synchronous clear restarts the period from zero.
module pedest_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic pulse
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Period counter, wraps at DIV-1; clear has priority over counting
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  // Pulse is independent of clr so the consumer may clear in response to it
  assign pulse = en & (cnt_r == LAST);

endmodule

// File: rtl/pedest_signal_out.sv
// Pedestrian WALK / DON'T-WALK lamp output device with CSR/DR register model.
// A 1-deep DR buffer feeds an IDLE/RUN sequencer that holds each command for
// its duration in ticks (0 = until preempted by the next buffered command).
// Optional feature macro: PEDEST_IRQ_EN (adds IE bit and registered irq).
module pedest_signal_out
  import pedest_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int FLASH_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       csr_wr,
  input  logic [7:0] csr_wdata,
  output logic [7:0] csr_rdata,
  input  logic       dr_wr,
  input  logic [7:0] dr_wdata,
  output logic       walk,
  output logic       dont_walk,
  output logic       irq
);

  pedest_state_t state_r;
  pedest_state_t state_n_s;

  logic       ena_r;
  logic       of_r;
  logic       buf_full_r;
  logic [7:0] buf_r;
  logic [1:0] cur_cmd_r;
  logic [5:0] cur_dur_r;
  logic [5:0] dur_cnt_r;
  logic       flash_phase_r;
  logic       walk_r;
  logic       dont_walk_r;
  logic       ie_s;

  logic       run_s;
  logic       kill_s;
  logic       load_s;
  logic       dr_accept_s;
  logic       of_set_s;
  logic       of_clr_s;
  logic       dur_last_s;
  logic       tick_s;
  logic       tick_clr_s;
  logic       flash_en_s;
  logic       flash_clr_s;
  logic       flash_tick_s;
  logic [1:0] cmd_n_s;
  logic       phase_n_s;
  logic [1:0] lamps_n_s;
  logic       unused_csr_bits_s;

  assign run_s = (state_r == ST_RUN);

  // Clearing ENA flushes everything on the same edge that drops ENA
  assign kill_s = csr_wr & ~csr_wdata[CSR_ENA] & ena_r;

  // A write into a buffer that drains this cycle is accepted, not an overrun
  assign dr_accept_s = dr_wr & ena_r & ~kill_s & (~buf_full_r | load_s);
  assign of_set_s    = dr_wr & ena_r & buf_full_r & ~load_s;
  assign of_clr_s    = csr_wr & ~csr_wdata[CSR_OF];

  assign dur_last_s = (cur_dur_r != 6'd0) && (dur_cnt_r == (cur_dur_r - 6'd1));

  assign tick_clr_s  = load_s | kill_s | ~run_s;
  assign flash_en_s  = run_s & (cur_cmd_r == CMD_FLASH);
  assign flash_clr_s = load_s | kill_s | ~flash_en_s;

  pedest_tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clr   (tick_clr_s),
    .en    (run_s),
    .pulse (tick_s)
  );

  pedest_tick_gen #(.DIV(FLASH_DIV)) u_flash_gen (
    .clk   (clk),
    .rst   (rst),
    .clr   (flash_clr_s),
    .en    (flash_en_s),
    .pulse (flash_tick_s)
  );

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next state and buffer-load decision; a finished command chains straight
  // into a waiting one without passing through IDLE
  always_comb begin
    state_n_s = state_r;
    load_s    = 1'b0;
    if (kill_s) begin
      state_n_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (buf_full_r) begin
            load_s    = 1'b1;
            state_n_s = ST_RUN;
          end else begin
            state_n_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cur_dur_r == 6'd0) begin
            if (buf_full_r) begin
              load_s = 1'b1;
            end else begin
              load_s = 1'b0;
            end
            state_n_s = ST_RUN;
          end else if (tick_s && dur_last_s) begin
            if (buf_full_r) begin
              load_s    = 1'b1;
              state_n_s = ST_RUN;
            end else begin
              state_n_s = ST_IDLE;
            end
          end else begin
            state_n_s = ST_RUN;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
        end
      endcase
    end
  end

  // Lamp values for the next cycle, so lamps change on the same edge as the state
  always_comb begin
    cmd_n_s   = cur_cmd_r;
    phase_n_s = flash_phase_r;
    lamps_n_s = 2'b01;
    if (load_s) begin
      cmd_n_s   = buf_r[1:0];
      phase_n_s = 1'b1;
    end else if (flash_tick_s) begin
      phase_n_s = ~flash_phase_r;
    end else begin
      phase_n_s = flash_phase_r;
    end
    if (state_n_s == ST_RUN) begin
      lamps_n_s = lamp_decode(cmd_n_s, phase_n_s);
    end else begin
      lamps_n_s = 2'b01;
    end
  end

  // CSR, DR buffer, current command, duration counter and lamp registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ena_r         <= 1'b0;
      of_r          <= 1'b0;
      buf_full_r    <= 1'b0;
      buf_r         <= 8'h00;
      cur_cmd_r     <= CMD_STOP;
      cur_dur_r     <= 6'd0;
      dur_cnt_r     <= 6'd0;
      flash_phase_r <= 1'b1;
      walk_r        <= 1'b0;
      dont_walk_r   <= 1'b1;
    end else begin
      if (csr_wr) begin
        ena_r <= csr_wdata[CSR_ENA];
      end
      of_r <= of_set_s | (of_r & ~of_clr_s);
      if (kill_s) begin
        buf_full_r <= 1'b0;
      end else if (dr_accept_s) begin
        buf_r      <= dr_wdata;
        buf_full_r <= 1'b1;
      end else if (load_s) begin
        buf_full_r <= 1'b0;
      end
      if (kill_s) begin
        dur_cnt_r     <= 6'd0;
        flash_phase_r <= 1'b1;
      end else if (load_s) begin
        cur_cmd_r     <= buf_r[1:0];
        cur_dur_r     <= buf_r[7:2];
        dur_cnt_r     <= 6'd0;
        flash_phase_r <= 1'b1;
      end else begin
        if (run_s && tick_s && (cur_dur_r != 6'd0)) begin
          dur_cnt_r <= dur_cnt_r + 6'd1;
        end
        flash_phase_r <= phase_n_s;
      end
      walk_r      <= lamps_n_s[1];
      dont_walk_r <= lamps_n_s[0];
    end
  end

`ifdef PEDEST_IRQ_EN
  logic ie_r;
  logic irq_r;

  // Interrupt enable and registered buffer-empty interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      ie_r  <= 1'b0;
      irq_r <= 1'b0;
    end else begin
      if (csr_wr) begin
        ie_r <= csr_wdata[CSR_IE];
      end
      irq_r <= ie_r & ena_r & ~buf_full_r;
    end
  end

  assign ie_s              = ie_r;
  assign irq               = irq_r;
  assign unused_csr_bits_s = ^csr_wdata[7:5];
`else
  assign ie_s              = 1'b0;
  assign irq               = 1'b0;
  assign unused_csr_bits_s = ^{csr_wdata[7:5], csr_wdata[CSR_IE]};
`endif

  assign csr_rdata = {3'b000, ena_r, of_r, ~buf_full_r, run_s, ie_s};
  assign walk      = walk_r;
  assign dont_walk = dont_walk_r;

endmodule

// File: tb/tb_pedest_signal_out.sv
// Directed self-checking bench for pedest_signal_out (TICK_DIV=4, FLASH_DIV=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pedest_signal_out;

  localparam int TICK_DIV  = 4;
  localparam int FLASH_DIV = 2;

  logic       clk;
  logic       rst;
  logic       csr_wr;
  logic [7:0] csr_wdata;
  logic [7:0] csr_rdata;
  logic       dr_wr;
  logic [7:0] dr_wdata;
  logic       walk;
  logic       dont_walk;
  logic       irq;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  pedest_signal_out #(.TICK_DIV(TICK_DIV), .FLASH_DIV(FLASH_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .csr_wr    (csr_wr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .dr_wr     (dr_wr),
    .dr_wdata  (dr_wdata),
    .walk      (walk),
    .dont_walk (dont_walk),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure run lengths
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic csr_write(input logic [7:0] v);
    @(negedge clk);
    csr_wr    = 1'b1;
    csr_wdata = v;
    @(negedge clk);
    csr_wr    = 1'b0;
  endtask

  task automatic dr_write(input logic [7:0] v);
    @(negedge clk);
    dr_wr    = 1'b1;
    dr_wdata = v;
    @(negedge clk);
    dr_wr    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int found;
    logic [7:0] pat;

    rst       = 1'b1;
    csr_wr    = 1'b0;
    csr_wdata = 8'h00;
    dr_wr     = 1'b0;
    dr_wdata  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1. Reset state
    check_eq("rst_csr", csr_rdata, 8'h04);
    check_eq("rst_walk", walk, 1'b0);
    check_eq("rst_dont_walk", dont_walk, 1'b1);
    check_eq("rst_irq", irq, 1'b0);

    // 2. WALK for 2 ticks = 8 cycles, starting two cycles after the write
    csr_write(8'h10);
    check_eq("t2_csr_ena", csr_rdata, 8'h14);
    dr_write(8'h09);
    check_eq("t2_buf_full_csr", csr_rdata, 8'h10);
    check_eq("t2_walk_not_yet", walk, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("t2_walk_%0d", i), walk, 1'b1);
      check_eq($sformatf("t2_busy_%0d", i), csr_rdata[1], 1'b1);
    end
    @(negedge clk);
    check_eq("t2_end_walk", walk, 1'b0);
    check_eq("t2_end_dont_walk", dont_walk, 1'b1);
    check_eq("t2_end_csr", csr_rdata, 8'h14);

    // 3. Overrun while running WALK x3, back-to-back load of FLASH x2
    dr_write(8'h0D);
    @(negedge clk);
    t0 = cyc;
    check_eq("t3_walk_start", walk, 1'b1);
    dr_write(8'h0A);
    dr_write(8'h0F);
    check_eq("t3_overrun_csr", csr_rdata, 8'h1A);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (walk == 1'b0) found = 1;
      else @(negedge clk);
    end
    check_eq("t3_walk_dropped", found, 1);
    check_eq("t3_run_len", cyc - t0, 12);
    check_eq("t3_no_gap_busy", csr_rdata[1], 1'b1);
    check_eq("t3_buf_drained", csr_rdata[2], 1'b1);
    pat = 8'b0011_0011;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t3_flash_%0d", i), dont_walk, pat[i]);
      check_eq($sformatf("t3_flash_walk_%0d", i), walk, 1'b0);
      check_eq($sformatf("t3_flash_busy_%0d", i), csr_rdata[1], 1'b1);
      @(negedge clk);
    end
    check_eq("t3_idle_csr", csr_rdata, 8'h1C);
    check_eq("t3_idle_dont_walk", dont_walk, 1'b1);
    csr_write(8'h10);
    check_eq("t3_of_cleared", csr_rdata, 8'h14);

    // 4. STOP hold, preempted by WALK x1
    dr_write(8'h03);
    @(negedge clk);
    check_eq("t4_hold_busy", csr_rdata[1], 1'b1);
    check_eq("t4_hold_dont_walk", dont_walk, 1'b1);
    repeat (5) @(negedge clk);
    check_eq("t4_still_holding", csr_rdata[1], 1'b1);
    dr_write(8'h05);
    @(negedge clk);
    check_eq("t4_preempt_walk", walk, 1'b1);
    check_eq("t4_preempt_dont_walk", dont_walk, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("t4_walk_%0d", i), walk, 1'b1);
    end
    @(negedge clk);
    check_eq("t4_end_busy", csr_rdata[1], 1'b0);
    check_eq("t4_end_walk", walk, 1'b0);

    // 5. Disable mid-run of FLASH with a full buffer
    dr_write(8'h06);
    @(negedge clk);
    check_eq("t5_flash_busy", csr_rdata[1], 1'b1);
    dr_write(8'h09);
    check_eq("t5_buf_full", csr_rdata[2], 1'b0);
    csr_write(8'h00);
    check_eq("t5_disabled_csr", csr_rdata, 8'h04);
    check_eq("t5_disabled_walk", walk, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t5_steady_%0d", i), dont_walk, 1'b1);
      @(negedge clk);
    end
    dr_write(8'h05);
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_ignored_csr", csr_rdata, 8'h04);
    check_eq("t5_ignored_walk", walk, 1'b0);

    // 6. Interrupt
    csr_write(8'h11);
`ifdef PEDEST_IRQ_EN
    check_eq("t6_csr", csr_rdata, 8'h15);
    check_eq("t6_irq_lag", irq, 1'b0);
    @(negedge clk);
    check_eq("t6_irq_up", irq, 1'b1);
    dr_write(8'h05);
    check_eq("t6_dba_low", csr_rdata[2], 1'b0);
    check_eq("t6_irq_still_up", irq, 1'b1);
    @(negedge clk);
    check_eq("t6_dba_high", csr_rdata[2], 1'b1);
    check_eq("t6_irq_down", irq, 1'b0);
    @(negedge clk);
    check_eq("t6_irq_back", irq, 1'b1);
`else
    check_eq("t6_csr_no_ie", csr_rdata, 8'h14);
    dr_write(8'h05);
    check_eq("t6_irq_0a", irq, 1'b0);
    @(negedge clk);
    check_eq("t6_irq_0b", irq, 1'b0);
    @(negedge clk);
    check_eq("t6_irq_0c", irq, 1'b0);
`endif
    repeat (6) @(negedge clk);

    // Reset in the middle of a run
    dr_write(8'h0D);
    @(negedge clk);
    check_eq("rr_busy", csr_rdata[1], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rr_csr", csr_rdata, 8'h04);
    check_eq("rr_walk", walk, 1'b0);
    check_eq("rr_dont_walk", dont_walk, 1'b1);
    check_eq("rr_irq", irq, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
